button_pio_irq: RTL

Parametrised Avalon-MM input PIO for board push-buttons and switches. It synchronises WIDTH asynchronous inputs and detects edges per bit into sticky capture bits. A per-bit mask gates the capture bits onto a level interrupt. It sits on the system interconnect as a slave, alongside the other PIOs under the Nios II processor.

---
 rtl/button_pio_irq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/button_pio_irq.sv
// Avalon-MM input PIO: synchronised buttons/switches, per-bit edge capture, masked level irq.
// Latency: readdata 1 clock after address; edge-to-capture SYNC_STAGES+1 clocks (+DEBOUNCE_CYCLES when debounced).
// Backpressure: none; the slave always accepts accesses (no waitrequest). Optional macro: BUTTON_PIO_DEBOUNCE_EN.
module button_pio_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // stable starts at 0, so hold off detection until it and prev have followed the idle inputs
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    // Reject parameter values the design was never meant to handle
    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("button_pio_irq: parameter out of range");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_in;
    logic [WIDTH-1:0]                  level;
    logic [WIDTH-1:0]                  prev;
    logic [WIDTH-1:0]                  edge_raw;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  irqmask;
    logic [WIDTH-1:0]                  edgecapture;
    logic [WIDTH-1:0]                  capture_clr;
    logic [WIDTH-1:0]                  rd_mux;
    logic [ARM_W-1:0]                  arm_cnt;
    logic                              armed;
    logic                              wr_en;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign wr_en   = chipselect & ~write_n;

    // Multi-stage synchroniser for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0][DB_W-1:0] db_cnt;
    logic [WIDTH-1:0]           stable;

    // Per-bit debounce: accept a new level only after it has held for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_in[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync_in[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = stable;
`else
    assign level = sync_in;
`endif

    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    // Arm counter: saturates once the pipeline holds real input, enabling edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    // Previous filtered level for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    // Edge polarity selection, gated until armed
    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = level & ~prev;
            1:       edge_raw = ~level & prev;
            default: edge_raw = level ^ prev;
        endcase
        edge_det = edge_raw & {WIDTH{armed}};
    end

    assign capture_clr = (wr_en && address == 2'd3) ? writedata : '0;

    // Mask register and sticky capture bits; a new edge beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata;
            end
            edgecapture <= (edgecapture & ~capture_clr) | edge_det;
        end
    end

    // Read mux for the current address
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = level;
            2'd2:    rd_mux = irqmask;
            2'd3:    rd_mux = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, reloaded every clock for a fixed one-clock latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule
